// File: rtl/vga_console_writer.sv
// Text console writer: turns a character stream into character-memory
// writes, with cursor tracking, newline/CR/backspace, hardware scroll and
// screen clear.
//
// Ports:
//   clk, rst              : clock, synchronous active-high reset
//   char_valid/char_ready : character handshake (accept when both high)
//   char_data             : ASCII code
//   char_fg, char_bg      : 12-bit colours for printable characters
//   clear_req             : one-cycle clear-screen request
//   mem_addr              : {row[4:0], col[6:0]} word address
//   mem_we, mem_wdata     : write strobe and {bg, fg, ascii}
//   mem_rdata             : read data, one clk after mem_addr
//   cursor_col/cursor_row : current cursor position
//   busy                  : high during scroll or clear
module vga_console_writer #(
   parameter int          VISIBLE_COLS = 80,
   parameter int          VISIBLE_ROWS = 30,
   parameter logic [11:0] DEFAULT_FG   = 12'hFFF,
   parameter logic [11:0] DEFAULT_BG   = 12'h000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        char_valid,
   input  logic [7:0]  char_data,
   input  logic [11:0] char_fg,
   input  logic [11:0] char_bg,
   input  logic        clear_req,
   output logic        char_ready,
   output logic [11:0] mem_addr,
   output logic        mem_we,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata,
   output logic [6:0]  cursor_col,
   output logic [4:0]  cursor_row,
   output logic        busy
);

   localparam logic [6:0] LAST_C = 7'(VISIBLE_COLS - 1);
   localparam logic [4:0] LAST_R = 5'(VISIBLE_ROWS - 1);
   localparam logic [31:0] FILL =
      {DEFAULT_BG, DEFAULT_FG, 8'h20};

   typedef enum logic [2:0] {
      IDLE,
      WRITE,
      SCR_RD,
      SCR_WR,
      SCR_FILL,
      CLR
   } state_t;

   state_t      state_q, state_d;
   logic [4:0]  row_q, row_d;
   logic [6:0]  col_q, col_d;
   logic [4:0]  sr_q, sr_d;
   logic [6:0]  sc_q, sc_d;
   logic        pend_q, pend_d;
   logic        bs_q, bs_d;
   logic [11:0] wa_q, wa_d;
   logic [31:0] wd_q, wd_d;

   logic        rdy;
   logic        accept;
   logic        fin;
   logic        is_print;
   logic        is_lf;
   logic        is_cr;
   logic        is_bs;

   assign is_print = (char_data >= 8'h20) &&
                     (char_data <= 8'h7E);
   assign is_lf    = (char_data == 8'h0A);
   assign is_cr    = (char_data == 8'h0D);
   assign is_bs    = (char_data == 8'h08);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         row_q   <= '0;
         col_q   <= '0;
         sr_q    <= '0;
         sc_q    <= '0;
         pend_q  <= 1'b0;
         bs_q    <= 1'b0;
         wa_q    <= '0;
         wd_q    <= '0;
      end else begin
         state_q <= state_d;
         row_q   <= row_d;
         col_q   <= col_d;
         sr_q    <= sr_d;
         sc_q    <= sc_d;
         pend_q  <= pend_d;
         bs_q    <= bs_d;
         wa_q    <= wa_d;
         wd_q    <= wd_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      row_d      = row_q;
      col_d      = col_q;
      sr_d       = sr_q;
      sc_d       = sc_q;
      pend_d     = pend_q;
      bs_d       = bs_q;
      wa_d       = wa_q;
      wd_d       = wd_q;
      fin        = 1'b0;
      mem_we     = 1'b0;
      mem_addr   = '0;
      mem_wdata  = '0;
      busy       = 1'b0;
      rdy        = (state_q == IDLE) && !pend_q &&
                   !clear_req;
      accept     = rdy && char_valid;
      char_ready = rdy;
      cursor_col = col_q;
      cursor_row = row_q;

      // Requests arriving mid-operation are held;
      // a clear already running absorbs them.
      if (clear_req && (state_q != IDLE) &&
          (state_q != CLR))
         pend_d = 1'b1;

      unique case (state_q)
         IDLE: begin
            if (clear_req || pend_q) begin
               state_d = CLR;
               sr_d    = '0;
               sc_d    = '0;
               pend_d  = 1'b0;
            end else if (accept) begin
               unique case (1'b1)
                  is_print: begin
                     state_d = WRITE;
                     bs_d    = 1'b0;
                     wa_d    = {row_q, col_q};
                     wd_d    = {char_bg, char_fg,
                                char_data};
                  end
                  is_lf: begin
                     col_d = '0;
                     if (row_q == LAST_R) begin
                        state_d = SCR_RD;
                        sr_d    = 5'd1;
                        sc_d    = '0;
                     end else begin
                        row_d = row_q + 5'd1;
                     end
                  end
                  is_cr: col_d = '0;
                  is_bs: begin
                     if (col_q != '0) begin
                        state_d = WRITE;
                        bs_d    = 1'b1;
                        wa_d    = {row_q,
                                   col_q - 7'd1};
                        wd_d    = {char_bg, char_fg,
                                   8'h20};
                     end
                  end
                  default: ;
               endcase
            end
         end

         WRITE: begin
            mem_we    = 1'b1;
            mem_addr  = wa_q;
            mem_wdata = wd_q;
            if (bs_q) begin
               col_d = col_q - 7'd1;
               fin   = 1'b1;
            end else if (col_q == LAST_C) begin
               col_d = '0;
               if (row_q == LAST_R) begin
                  state_d = SCR_RD;
                  sr_d    = 5'd1;
                  sc_d    = '0;
               end else begin
                  row_d = row_q + 5'd1;
                  fin   = 1'b1;
               end
            end else begin
               col_d = col_q + 7'd1;
               fin   = 1'b1;
            end
         end

         SCR_RD: begin
            busy     = 1'b1;
            mem_addr = {sr_q, sc_q};
            state_d  = SCR_WR;
         end

         // Read data for the cell addressed last
         // cycle is forwarded straight to the row above.
         SCR_WR: begin
            busy      = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = {sr_q - 5'd1, sc_q};
            mem_wdata = mem_rdata;
            if (sc_q == LAST_C) begin
               sc_d = '0;
               if (sr_q == LAST_R) begin
                  state_d = SCR_FILL;
               end else begin
                  sr_d    = sr_q + 5'd1;
                  state_d = SCR_RD;
               end
            end else begin
               sc_d    = sc_q + 7'd1;
               state_d = SCR_RD;
            end
         end

         SCR_FILL: begin
            busy      = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = {LAST_R, sc_q};
            mem_wdata = FILL;
            if (sc_q == LAST_C)
               fin = 1'b1;
            else
               sc_d = sc_q + 7'd1;
         end

         CLR: begin
            busy      = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = {sr_q, sc_q};
            mem_wdata = FILL;
            if (sc_q == LAST_C) begin
               sc_d = '0;
               if (sr_q == LAST_R) begin
                  row_d   = '0;
                  col_d   = '0;
                  state_d = IDLE;
               end else begin
                  sr_d = sr_q + 5'd1;
               end
            end else begin
               sc_d = sc_q + 7'd1;
            end
         end

         default: state_d = IDLE;
      endcase

      // A pending clear starts as soon as the
      // current operation ends.
      if (fin) begin
         if (pend_q || clear_req) begin
            state_d = CLR;
            sr_d    = '0;
            sc_d    = '0;
            pend_d  = 1'b0;
         end else begin
            state_d = IDLE;
         end
      end

      // Reset cycle: all outputs quiet at once.
      if (rst) begin
         mem_we     = 1'b0;
         mem_addr   = '0;
         mem_wdata  = '0;
         busy       = 1'b0;
         char_ready = 1'b0;
         cursor_col = '0;
         cursor_row = '0;
      end
   end

endmodule

// File: tb/tb_vga_console_writer.sv
// Directed bench for vga_console_writer with a
// 1-cycle-latency character memory model.
module tb_vga_console_writer;

   logic        clk = 1'b0;
   logic        rst;
   logic        char_valid;
   logic [7:0]  char_data;
   logic [11:0] char_fg;
   logic [11:0] char_bg;
   logic        clear_req;
   logic        char_ready;
   logic [11:0] mem_addr;
   logic        mem_we;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic [6:0]  cursor_col;
   logic [4:0]  cursor_row;
   logic        busy;

   int checks = 0;
   int errors = 0;

   int          we_total = 0;
   int          fill_total = 0;
   int          busy_total = 0;
   logic [11:0] last_addr = '0;
   logic [31:0] last_wdata = '0;

   logic [31:0] mem [0:4095];

   always #5 clk = ~clk;

   vga_console_writer dut (
      .clk        (clk),
      .rst        (rst),
      .char_valid (char_valid),
      .char_data  (char_data),
      .char_fg    (char_fg),
      .char_bg    (char_bg),
      .clear_req  (clear_req),
      .char_ready (char_ready),
      .mem_addr   (mem_addr),
      .mem_we     (mem_we),
      .mem_wdata  (mem_wdata),
      .mem_rdata  (mem_rdata),
      .cursor_col (cursor_col),
      .cursor_row (cursor_row),
      .busy       (busy)
   );

   always @(posedge clk) begin
      mem_rdata <= mem[mem_addr];
      if (mem_we)
         mem[mem_addr] <= mem_wdata;
   end

   always @(negedge clk) begin
      if (mem_we) begin
         we_total   <= we_total + 1;
         last_addr  <= mem_addr;
         last_wdata <= mem_wdata;
         if (mem_wdata == 32'h000FFF20)
            fill_total <= fill_total + 1;
      end
      if (busy)
         busy_total <= busy_total + 1;
   end

   task automatic apply_reset();
      @(posedge clk); #1;
      rst        = 1'b1;
      char_valid = 1'b0;
      char_data  = '0;
      char_fg    = '0;
      char_bg    = '0;
      clear_req  = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   task automatic send_char(input logic [7:0] c,
                            input logic [11:0] fg,
                            input logic [11:0] bg);
      bit ok;
      ok = 1'b0;
      @(posedge clk); #1;
      char_valid = 1'b1;
      char_data  = c;
      char_fg    = fg;
      char_bg    = bg;
      for (int i = 0; i < 20000 && !ok; i++) begin
         @(negedge clk);
         if (char_ready) ok = 1'b1;
      end
      @(posedge clk); #1;
      char_valid = 1'b0;
      if (!ok) begin
         checks++; errors++;
         $display("FAIL accept_timeout code=%h", c);
      end
   endtask

   task automatic wait_ready(input int max);
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < max && !ok; i++) begin
         @(negedge clk);
         if (char_ready) ok = 1'b1;
      end
      #1;
      if (!ok) begin
         checks++; errors++;
         $display("FAIL ready_timeout after %0d", max);
      end
   endtask

   task automatic put_char(input logic [7:0] c,
                           input logic [11:0] fg,
                           input logic [11:0] bg);
      send_char(c, fg, bg);
      wait_ready(20000);
   endtask

   task automatic check_cursor(input string nm,
                               input logic [4:0] r,
                               input logic [6:0] c);
      checks++;
      if (cursor_row !== r || cursor_col !== c) begin
         errors++;
         $display("FAIL %s cursor got (%0d,%0d) exp (%0d,%0d)",
                  nm, cursor_row, cursor_col, r, c);
      end
   endtask

   task automatic test_reset();
      @(posedge clk); #1;
      rst        = 1'b1;
      char_valid = 1'b1;
      char_data  = 8'h41;
      char_fg    = '0;
      char_bg    = '0;
      clear_req  = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checks++;
      if (char_ready !== 1'b0 || mem_we !== 1'b0 ||
          busy !== 1'b0 || mem_addr !== 12'h0 ||
          mem_wdata !== 32'h0) begin
         errors++;
         $display("FAIL rst_outputs rdy=%b we=%b busy=%b a=%h d=%h exp 0",
                  char_ready, mem_we, busy, mem_addr,
                  mem_wdata);
      end
      @(posedge clk); #1;
      rst        = 1'b0;
      char_valid = 1'b0;
      @(negedge clk);
      checks++;
      if (char_ready !== 1'b1) begin
         errors++;
         $display("FAIL idle_ready got %b exp 1",
                  char_ready);
      end
      check_cursor("reset", 5'd0, 7'd0);
   endtask

   task automatic test_single_char();
      int w0;
      w0 = we_total;
      put_char(8'h41, 12'h0F0, 12'h00F);
      checks++;
      if (we_total - w0 != 1 || last_addr !== 12'h000 ||
          last_wdata !== 32'h00F0F041) begin
         errors++;
         $display("FAIL char_A n=%0d a=%h d=%h exp 1 000 00F0F041",
                  we_total - w0, last_addr, last_wdata);
      end
      check_cursor("char_A", 5'd0, 7'd1);
   endtask

   task automatic test_line_wrap();
      int w0;
      apply_reset();
      w0 = we_total;
      for (int i = 0; i < 80; i++)
         put_char(8'(8'h30 + (i % 10)), 12'h111, 12'h222);
      checks++;
      if (we_total - w0 != 80 || last_addr !== 12'h04F ||
          last_wdata !== 32'h22211139) begin
         errors++;
         $display("FAIL wrap n=%0d a=%h d=%h exp 80 04F 22211139",
                  we_total - w0, last_addr, last_wdata);
      end
      check_cursor("wrap", 5'd1, 7'd0);
   endtask

   task automatic test_backspace();
      int w0;
      w0 = we_total;
      put_char(8'h08, 12'h0AB, 12'h0CD);
      checks++;
      if (we_total - w0 != 0) begin
         errors++;
         $display("FAIL bs_col0 writes got %0d exp 0",
                  we_total - w0);
      end
      check_cursor("bs_col0", 5'd1, 7'd0);
      for (int i = 0; i < 3; i++)
         put_char(8'h78, 12'h0AB, 12'h0CD);
      w0 = we_total;
      put_char(8'h08, 12'h0AB, 12'h0CD);
      checks++;
      if (we_total - w0 != 1 || last_addr !== 12'h082 ||
          last_wdata !== 32'h0CD0AB20) begin
         errors++;
         $display("FAIL bs_col3 n=%0d a=%h d=%h exp 1 082 0CD0AB20",
                  we_total - w0, last_addr, last_wdata);
      end
      check_cursor("bs_col3", 5'd1, 7'd2);
   endtask

   task automatic test_cr_other();
      int w0;
      w0 = we_total;
      put_char(8'h07, 12'h0AB, 12'h0CD);
      check_cursor("bell", 5'd1, 7'd2);
      put_char(8'h0D, 12'h0AB, 12'h0CD);
      check_cursor("cr", 5'd1, 7'd0);
      checks++;
      if (we_total - w0 != 0) begin
         errors++;
         $display("FAIL cr_other writes got %0d exp 0",
                  we_total - w0);
      end
   endtask

   task automatic test_scroll();
      int b0;
      int bad;
      logic [11:0] a;
      apply_reset();
      put_char(8'h0A, 12'h0, 12'h0);
      for (int i = 0; i < 6; i++)
         put_char(8'(8'h30 + i), 12'h123, 12'h456);
      for (int i = 0; i < 28; i++)
         put_char(8'h0A, 12'h0, 12'h0);
      check_cursor("row29", 5'd29, 7'd0);
      b0 = busy_total;
      put_char(8'h0A, 12'h0, 12'h0);
      checks++;
      if (busy_total - b0 != 4720) begin
         errors++;
         $display("FAIL scroll_busy got %0d exp 4720",
                  busy_total - b0);
      end
      checks++;
      if (mem[5] !== 32'h45612335 ||
          mem[0] !== 32'h45612330) begin
         errors++;
         $display("FAIL scroll_copy got %h %h exp 45612335 45612330",
                  mem[5], mem[0]);
      end
      bad = 0;
      for (int c = 0; c < 80; c++) begin
         a = {5'd29, 7'(c)};
         if (mem[a] !== 32'h000FFF20) bad++;
      end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL scroll_fill bad cells %0d exp 0", bad);
      end
      check_cursor("scroll", 5'd29, 7'd0);
   endtask

   task automatic test_clear();
      int w0;
      int f0;
      w0 = we_total;
      f0 = fill_total;
      @(posedge clk); #1;
      clear_req  = 1'b1;
      char_valid = 1'b1;
      char_data  = 8'h5A;
      char_fg    = 12'h0F0;
      char_bg    = 12'h00F;
      @(negedge clk);
      checks++;
      if (char_ready !== 1'b0) begin
         errors++;
         $display("FAIL clr_prio ready got %b exp 0",
                  char_ready);
      end
      @(posedge clk); #1;
      clear_req  = 1'b0;
      char_valid = 1'b0;
      wait_ready(5000);
      checks++;
      if (we_total - w0 != 2400 ||
          fill_total - f0 != 2400) begin
         errors++;
         $display("FAIL clear n=%0d fill=%0d exp 2400 2400",
                  we_total - w0, fill_total - f0);
      end
      check_cursor("clear", 5'd0, 7'd0);
   endtask

   task automatic test_pending_merge();
      int w0;
      int b0;
      for (int i = 0; i < 29; i++)
         put_char(8'h0A, 12'h0, 12'h0);
      w0 = we_total;
      b0 = busy_total;
      send_char(8'h0A, 12'h0, 12'h0);
      repeat (10) @(posedge clk);
      #1 clear_req = 1'b1;
      @(posedge clk);
      #1 clear_req = 1'b0;
      repeat (200) @(posedge clk);
      #1 clear_req = 1'b1;
      @(posedge clk);
      #1 clear_req = 1'b0;
      wait_ready(20000);
      checks++;
      if (we_total - w0 != 4800 ||
          busy_total - b0 != 7120) begin
         errors++;
         $display("FAIL pend n=%0d busy=%0d exp 4800 7120",
                  we_total - w0, busy_total - b0);
      end
      check_cursor("pend", 5'd0, 7'd0);
   endtask

   task automatic test_reset_mid_scroll();
      int w0;
      apply_reset();
      for (int i = 0; i < 29; i++)
         put_char(8'h0A, 12'h0, 12'h0);
      send_char(8'h0A, 12'h0, 12'h0);
      repeat (99) @(posedge clk);
      #1 rst = 1'b1;
      @(negedge clk);
      checks++;
      if (mem_we !== 1'b0 || char_ready !== 1'b0) begin
         errors++;
         $display("FAIL midrst_cycle we=%b rdy=%b exp 0 0",
                  mem_we, char_ready);
      end
      @(posedge clk);
      #1 rst = 1'b0;
      w0 = we_total;
      repeat (50) @(negedge clk);
      #1;
      checks++;
      if (we_total - w0 != 0 || busy !== 1'b0 ||
          char_ready !== 1'b1) begin
         errors++;
         $display("FAIL midrst n=%0d busy=%b rdy=%b exp 0 0 1",
                  we_total - w0, busy, char_ready);
      end
      check_cursor("midrst", 5'd0, 7'd0);
   endtask

   initial begin
      rst        = 1'b1;
      char_valid = 1'b0;
      char_data  = '0;
      char_fg    = '0;
      char_bg    = '0;
      clear_req  = 1'b0;
      test_reset();
      test_single_char();
      test_line_wrap();
      test_backspace();
      test_cr_other();
      test_scroll();
      test_clear();
      test_pending_merge();
      test_reset_mid_scroll();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/vga_console_writer.md
VGA_CONSOLE_WRITER -- requirements
Module: vga_console_writer

Interface
REQ-001 Parameter VISIBLE_COLS, default 80, number of visible text columns (1..128).
REQ-002 Parameter VISIBLE_ROWS, default 30, number of visible text rows (2..32).
REQ-003 Parameter DEFAULT_FG, default 12'hFFF, foreground colour used for clear and scroll fill.
REQ-004 Parameter DEFAULT_BG, default 12'h000, background colour used for clear and scroll fill.
REQ-005 clk  input  1  single clock for all logic.
REQ-006 rst  input  1  reset, synchronous, active-high.
REQ-007 char_valid  input  1  character request valid.
REQ-008 char_data  input  8  ASCII code.
REQ-009 char_fg / char_bg  input  12 / 12  colours for printable characters.
REQ-010 clear_req  input  1  one-cycle request to clear the screen.
REQ-011 char_ready  output  1  high when a character is accepted this cycle.
REQ-012 mem_addr  output  12  character memory word address: bits [11:7] row, bits [6:0] column.
REQ-013 mem_we  output  1  write strobe to the character memory data port.
REQ-014 mem_wdata  output  32  {bg[31:20], fg[19:8], ascii[7:0]}.
REQ-015 mem_rdata  input  32  data-port read value, valid one clk after mem_addr is presented.
REQ-016 cursor_col / cursor_row  output  7 / 5  current cursor position.
REQ-017 busy  output  1  high while a clear or scroll is in progress.

Function
REQ-018 The block SHALL use states IDLE, WRITE, SCR_RD, SCR_WR, SCR_FILL and CLR.
REQ-019 A character SHALL be accepted when char_valid and char_ready are both high; char_ready SHALL equal (state==IDLE) && !clear_pending && !clear_req.
REQ-020 When a printable code (0x20-0x7E) is accepted, the block SHALL enter WRITE and, in the next cycle, drive mem_we=1, mem_addr={cursor_row,cursor_col}, and mem_wdata={char_bg,char_fg,char_data}, with all three registered.
REQ-021 After the write, cursor_col SHALL increment; if it was VISIBLE_COLS-1, it SHALL wrap to 0 and a newline SHALL be applied.
REQ-022 For 0x0A, the block SHALL apply a newline: cursor_col=0 and cursor_row+1; if cursor_row was VISIBLE_ROWS-1, the block SHALL enter scroll and cursor_row SHALL stay at VISIBLE_ROWS-1.
REQ-023 For 0x0D, the block SHALL set cursor_col=0 with no memory write.
REQ-024 For 0x08, if cursor_col>0, the block SHALL decrement cursor_col and write a space (0x20 with char_fg/char_bg) at the new position; if cursor_col==0, it SHALL do nothing.
REQ-025 For all other codes, the character SHALL be consumed with no write and no cursor change.
REQ-026 Scroll, for r=1..VISIBLE_ROWS-1 and c=0..VISIBLE_COLS-1 in row-major order:
- SCR_RD: present mem_addr={r,c} with mem_we=0.
- SCR_WR: write mem_rdata to {r-1,c}.
REQ-027 After the last copy, SCR_FILL SHALL write {DEFAULT_BG,DEFAULT_FG,8'h20} to every column of row VISIBLE_ROWS-1, one per cycle, and then return to IDLE.
REQ-028 Scroll duration SHALL be exactly 2*VISIBLE_COLS*(VISIBLE_ROWS-1)+VISIBLE_COLS cycles with busy=1 throughout.
REQ-029 CLR SHALL write {DEFAULT_BG,DEFAULT_FG,8'h20} to every visible cell, one per cycle in row-major order, for VISIBLE_COLS*VISIBLE_ROWS cycles; cursor SHALL then be (0,0) and the block SHALL return to IDLE.
REQ-030 clear_req in IDLE SHALL take priority over a simultaneous char_valid, and that character SHALL NOT be accepted.
REQ-031 clear_req while not IDLE SHALL set clear_pending; CLR SHALL start immediately after the current operation completes; multiple requests SHALL merge into one clear.
REQ-032 Addresses for columns >= VISIBLE_COLS or rows >= VISIBLE_ROWS SHALL never be driven.
REQ-033 mem_we SHALL be 0 in IDLE and SCR_RD.

Reset
REQ-034 On rst, the block SHALL force state=IDLE, cursor=(0,0), mem_we=0, mem_addr=0, mem_wdata=0, busy=0, clear_pending=0, and char_ready=0 during the rst cycle.
REQ-035 rst asserted mid-scroll or mid-clear SHALL abort the operation with no further writes; memory contents SHALL be left as-is.

Verification
REQ-036 Reset, then send 'A' (0x41) with fg=12'h0F0 and bg=12'h00F: mem_we pulses once at addr 0 with wdata=32'h00F0F041, and the cursor becomes (row 0, col 1).
REQ-037 Send 80 printable characters from (0,0): the last write is at addr 0x04F, and the cursor becomes (row 1, col 0).
REQ-038 Set the cursor to row 29 and send 0x0A with a behavioural 1-cycle-latency memory model: the copy from addr {1,5} lands at {0,5}, row 29 is all 32'h000FFF20, busy lasts 4720 cycles, and the cursor is (29,0).
REQ-039 clear_req and char_valid asserted together in IDLE: the character is not accepted, there are 2400 writes of 32'h000FFF20, and the cursor is (0,0).
REQ-040 Backspace at col 0: no write occurs. Backspace at col 3: a space is written at col 2 and the cursor col becomes 2.
REQ-041 rst asserted 100 cycles into a scroll: there is no mem_we afterwards, state is IDLE, and the cursor is (0,0).
